// File: rtl/rd_burst_fmt.sv
// rd_burst_fmt: buffers memory read-return words in a circular FIFO and re-emits them
// as whole, gap-free bursts. The first word of each burst is flagged on rdata_bvld.
// A flush pulse releases a trailing partial burst. Overflow drops are counted.
module rd_burst_fmt #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned BL_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_vld,
  input  logic [BL_W-1:0]        burst_len,
  input  logic                   flush,
  output logic [DW-1:0]          rdata,
  output logic                   rdata_vld,
  output logic                   rdata_bvld,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf,
  output logic [15:0]            drop_cnt,
  output logic                   busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  // Wide enough for both an occupancy value and any burst length.
  localparam int unsigned RW = (BL_W > CW) ? BL_W : CW;

  typedef enum logic [1:0] {StIdle, StBurst, StFlush} state_e;

  state_e        state_q;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [RW-1:0] rem_q;         // pops still owed after entering BURST/FLUSH
  logic          flush_pend_q;

  logic [RW-1:0] occ;
  logic [RW-1:0] len_eff;
  logic          full;
  logic          quiet;
  logic          start_burst;
  logic          start_flush;
  logic          pop;
  logic          push;
  logic          drop;
  logic          pend_clr;

  // Decide pops, pushes and drops for this cycle.
  always_comb begin
    occ         = RW'(fifo_cnt);
    len_eff     = (burst_len == '0) ? RW'(1) : RW'(burst_len);
    full        = (fifo_cnt == CW'(DEPTH));
    // A new burst may only start in IDLE once the previous burst's last word has
    // left the output register, which guarantees one idle cycle between bursts.
    quiet       = (state_q == StIdle) && !rdata_vld;
    start_burst = quiet && (occ >= len_eff);
    start_flush = quiet && !start_burst && flush_pend_q && (fifo_cnt != '0);
    // The cycle that leaves IDLE already pops the first word.
    pop         = start_burst || start_flush || (state_q != StIdle);
    push        = in_vld && (!full || pop);
    drop        = in_vld && full && !pop;
    pend_clr    = start_flush || ((state_q == StIdle) && (fifo_cnt == '0));
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Pointers, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_cnt <= '0;
      ovf      <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Burst state machine with registered output word and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      flush_pend_q <= 1'b0;
      rdata        <= '0;
      rdata_vld    <= 1'b0;
      rdata_bvld   <= 1'b0;
    end else begin
      flush_pend_q <= flush || (flush_pend_q && !pend_clr);
      rdata_vld    <= pop;
      rdata_bvld   <= start_burst || start_flush;
      if (pop) rdata <= mem[rd_ptr_q];
      unique case (state_q)
        StIdle: begin
          // A single-word burst or flush completes in the start cycle itself.
          if (start_burst) begin
            rem_q   <= len_eff - RW'(1);
            state_q <= (len_eff == RW'(1)) ? StIdle : StBurst;
          end else if (start_flush) begin
            rem_q   <= occ - RW'(1);
            state_q <= (occ == RW'(1)) ? StIdle : StFlush;
          end
        end
        StBurst, StFlush: begin
          rem_q <= rem_q - RW'(1);
          if (rem_q == RW'(1)) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_rd_burst_fmt.sv
// Bench for rd_burst_fmt: directed scenarios plus random traffic, all checked each
// cycle against a queue-based reference model.
module tb_rd_burst_fmt;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned BL_W  = 5;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [DW-1:0]   in_data;
  logic            in_vld;
  logic [BL_W-1:0] burst_len;
  logic            flush;
  logic [DW-1:0]   rdata;
  logic            rdata_vld;
  logic            rdata_bvld;
  logic [CW-1:0]   fifo_cnt;
  logic            ovf;
  logic [15:0]     drop_cnt;
  logic            busy;

  rd_burst_fmt #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .BL_W (BL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .burst_len (burst_len),
    .flush     (flush),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .rdata_bvld(rdata_bvld),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: word queue, words still owed to the current burst, pending flush.
  logic [DW-1:0] q [$];
  int            owed   = 0;
  bit            pend   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_vld  = 1'b0;
  bit            m_bvld = 1'b0;
  bit            m_ovf  = 1'b0;
  int            m_drop = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int occ;
    int len;
    bit popn;
    bit first;
    bit clr;
    if (rst) begin
      q.delete();
      owed    = 0;
      pend    = 1'b0;
      m_rdata = '0;
      m_vld   = 1'b0;
      m_bvld  = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
      return;
    end
    occ   = q.size();
    len   = (burst_len == '0) ? 1 : int'(burst_len);
    popn  = 1'b0;
    first = 1'b0;
    clr   = 1'b0;
    if (owed == 0) begin
      if (!m_vld && occ >= len) begin
        owed  = len;
        first = 1'b1;
      end else if (!m_vld && pend && occ > 0) begin
        owed  = occ;
        first = 1'b1;
        clr   = 1'b1;
      end
      if (occ == 0) clr = 1'b1;
    end
    if (owed > 0) begin
      popn    = 1'b1;
      owed--;
      m_rdata = q.pop_front();
    end
    m_vld  = popn;
    m_bvld = first;
    pend   = flush || (pend && !clr);
    if (in_vld) begin
      if (occ < int'(DEPTH) || popn) begin
        q.push_back(in_data);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
  endtask

  // One clock: model update at the edge, compare all outputs at the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("vld", rdata_vld, m_vld);
    check_eq("bvld", rdata_bvld, m_bvld);
    check_eq("rdata", rdata, m_rdata);
    check_eq("cnt", fifo_cnt, q.size());
    check_eq("ovf", ovf, m_ovf);
    check_eq("drop", drop_cnt, m_drop);
    check_eq("busy", busy, owed > 0);
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit f);
    in_vld  = v;
    in_data = d;
    flush   = f;
    tick();
  endtask

  initial begin
    int n;
    bit exp_v;
    rst       = 1'b1;
    in_vld    = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    burst_len = 5'd4;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_cnt", fifo_cnt, 0);
    check_eq("rst_busy", busy, 0);

    // Single burst, L = 4: words appear on cycles 5..8.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 1'b0);
    check_eq("sb_early", rdata_vld, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b0);
      check_eq("sb_word", rdata, 32'h10 + i);
      check_eq("sb_vld", rdata_vld, 1);
      check_eq("sb_bvld", rdata_bvld, i == 0);
    end
    drive(1'b0, '0, 1'b0);
    check_eq("sb_end", rdata_vld, 0);
    check_eq("sb_cnt", fifo_cnt, 0);

    // Stalled input, L = 4.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h20 + i, 1'b0);
      repeat (3) drive(1'b0, '0, 1'b0);
    end
    repeat (8) drive(1'b0, '0, 1'b0);

    // Back-to-back bursts, L = 2: exactly one idle cycle between bursts.
    burst_len = 5'd2;
    for (int c = 1; c <= 14; c++) begin
      if (c <= 6) drive(1'b1, 32'h30 + c - 1, 1'b0);
      else drive(1'b0, '0, 1'b0);
      exp_v = (c == 3) || (c == 4) || (c == 6) || (c == 7) || (c == 9) || (c == 10);
      check_eq("b2b_vld", rdata_vld, exp_v);
      check_eq("b2b_bvld", rdata_bvld, (c == 3) || (c == 6) || (c == 9));
    end

    // Flush a 3-word partial burst, L = 8.
    burst_len = 5'd8;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h40 + i, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b1);
    check_eq("fl_wait", rdata_vld, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b0);
      check_eq("fl_word", rdata, 32'h40 + i);
      check_eq("fl_vld", rdata_vld, 1);
      check_eq("fl_bvld", rdata_bvld, i == 0);
    end
    drive(1'b0, '0, 1'b0);
    check_eq("fl_end", rdata_vld, 0);
    check_eq("fl_busy", busy, 0);
    drive(1'b0, '0, 1'b1);
    repeat (4) begin
      drive(1'b0, '0, 1'b0);
      check_eq("fl_empty", rdata_vld, 0);
    end

    // Overflow: L larger than DEPTH so nothing pops until a flush.
    burst_len = 5'd17;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 32'h100 + i, 1'b0);
      if (i == 15) check_eq("ovf_pre", ovf, 0);
      if (i == 16) check_eq("ovf_rise", ovf, 1);
    end
    in_vld = 1'b0;
    check_eq("ovf_flag", ovf, 1);
    check_eq("ovf_drops", drop_cnt, 4);
    check_eq("ovf_full", fifo_cnt, 16);
    drive(1'b0, '0, 1'b1);
    n = 0;
    repeat (20) begin
      drive(1'b0, '0, 1'b0);
      if (rdata_vld) begin
        check_eq("ovf_word", rdata, 32'h100 + n);
        n++;
      end
    end
    check_eq("ovf_nwords", n, 16);

    // Reset on the 3rd word of an L = 8 burst.
    burst_len = 5'd8;
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h200 + i, 1'b0);
    n = 0;
    for (int k = 0; k < 30 && n < 3; k++) begin
      drive(1'b0, '0, 1'b0);
      if (rdata_vld) n++;
    end
    check_eq("rmb_reach", n, 3);
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    check_eq("rmb_vld", rdata_vld, 0);
    check_eq("rmb_cnt", fifo_cnt, 0);
    check_eq("rmb_ovf", ovf, 0);
    check_eq("rmb_drop", drop_cnt, 0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h300 + i, 1'b0);
    n = 0;
    repeat (14) begin
      drive(1'b0, '0, 1'b0);
      if (rdata_vld) begin
        check_eq("rmb_word", rdata, 32'h300 + n);
        n++;
      end
    end
    check_eq("rmb_nwords", n, 8);

    // Random traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 63) == 0) burst_len = BL_W'($urandom_range(0, 16));
      rst = ($urandom_range(0, 999) == 0);
      drive($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 39) == 0);
    end
    rst = 1'b0;
    repeat (40) drive(1'b0, '0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
